// File: rtl/imdct_overlap_add_pkg.sv
// Shared constants and the controller state type for the IMDCT overlap-add block.
//   N_DEF        : default sample width (signed, two's complement)
//   SUBBANDS_DEF : default subbands per granule
//   HALF_DEF     : default half IMDCT block length
//   DEPTH_DEF    : overlap memory depth in words (SUBBANDS_DEF*HALF_DEF)
package imdct_pkg;

    localparam int N_DEF        = 18;
    localparam int SUBBANDS_DEF = 32;
    localparam int HALF_DEF     = 18;
    localparam int DEPTH_DEF    = SUBBANDS_DEF * HALF_DEF;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/imdct_overlap_add_if.sv
// Sample stream interface for the overlap-add block.
//   in_valid / in_ready / in_sample              : IMDCT samples into the block
//   out_valid / out_ready / out_sample / out_last : overlap-added samples out
// master : the environment (drives inputs, accepts outputs)
// slave  : the overlap-add block
interface imdct_overlap_add_if
    import imdct_pkg::*;
#(
    parameter int N = N_DEF
);
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_sample;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_sample;
    logic                out_last;

    modport master (
        output in_valid, in_sample, out_ready,
        input  in_ready, out_valid, out_sample, out_last
    );

    modport slave (
        input  in_valid, in_sample, out_ready,
        output in_ready, out_valid, out_sample, out_last
    );
endinterface

// File: rtl/imdct_overlap_add_ram.sv
// Overlap memory: DEPTH x N words, one synchronous write port and one
// asynchronous read port. Contents are not reset; the controller zeroes them.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module overlap_ram #(
    parameter int N     = 18,
    parameter int DEPTH = 576,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic signed [N-1:0] i_wdata,
    input  logic [AW-1:0]       i_raddr,
    output logic signed [N-1:0] o_rdata
);
    logic signed [N-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/imdct_overlap_add.sv
// IMDCT overlap-add: the first half of each subband block is added to the
// stored second half of the previous granule and emitted saturated; the second
// half is stored for the next granule.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   clear : one-cycle pulse, restarts memory clearing (new stream/channel)
//   bus   : sample stream interface (slave side)
//
// state    | meaning
// ST_CLEAR | zeroing overlap memory one word per cycle, input stalled
// ST_RUN   | accepting samples, producing overlap-added outputs
module imdct_overlap_add
    import imdct_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int SUBBANDS = SUBBANDS_DEF,
    parameter int HALF     = HALF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    imdct_overlap_add_if.slave bus
);
    localparam int DEPTH = SUBBANDS * HALF;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(2 * HALF);
    localparam int SW    = (SUBBANDS > 1) ? $clog2(SUBBANDS) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_clr_addr;
    logic [IW-1:0]       r_idx;
    logic [SW-1:0]       r_sb;
    logic                r_out_valid;
    logic                r_out_last;
    logic signed [N-1:0] r_out_sample;

    logic                w_second_half;
    logic                w_in_ready;
    logic                w_hs;
    logic                w_clr_done;
    logic [IW-1:0]       w_idx_lo;
    logic [AW-1:0]       w_addr;
    logic                w_we;
    logic [AW-1:0]       w_waddr;
    logic signed [N-1:0] w_wdata;
    logic signed [N-1:0] w_rdata;
    logic signed [N:0]   w_sum;
    logic signed [N-1:0] w_sat;

    assign w_second_half = (r_idx >= IW'(HALF));
    // Second-half samples only write memory, so they never wait on the output.
    assign w_in_ready    = (r_state == ST_RUN) &&
                           (w_second_half || !r_out_valid || bus.out_ready);
    assign w_hs          = bus.in_valid && w_in_ready;
    assign w_clr_done    = (r_clr_addr == AW'(DEPTH - 1));
    assign w_idx_lo      = w_second_half ? (r_idx - IW'(HALF)) : r_idx;
    assign w_addr        = AW'(r_sb) * AW'(HALF) + AW'(w_idx_lo);

    assign w_sum = {bus.in_sample[N-1], bus.in_sample} + {w_rdata[N-1], w_rdata};

    always_comb begin
        w_sat = w_sum[N-1:0];
        if (w_sum[N] != w_sum[N-1]) begin
            w_sat = w_sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = w_addr;
        w_wdata     = '0;
        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                if (w_clr_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_hs && w_second_half) begin
                    w_we    = 1'b1;
                    w_wdata = bus.in_sample;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
        if (clear) begin
            w_state_nxt = ST_CLEAR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr <= '0;
        end else if (clear) begin
            r_clr_addr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_addr <= w_clr_done ? '0 : r_clr_addr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_sb  <= '0;
        end else if (clear) begin
            r_idx <= '0;
            r_sb  <= '0;
        end else if (w_hs) begin
            if (r_idx == IW'(2 * HALF - 1)) begin
                r_idx <= '0;
                r_sb  <= (r_sb == SW'(SUBBANDS - 1)) ? '0 : r_sb + SW'(1);
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            r_out_last   <= 1'b0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_hs && !w_second_half) begin
            r_out_valid  <= 1'b1;
            r_out_sample <= w_sat;
            r_out_last   <= (r_sb == SW'(SUBBANDS - 1)) && (r_idx == IW'(HALF - 1));
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    overlap_ram #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_addr),
        .o_rdata (w_rdata)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_sample = r_out_sample;
    assign bus.out_last   = r_out_last;
endmodule

// File: tb/tb_imdct_overlap_add.sv
module tb_imdct_overlap_add;
    import imdct_pkg::*;

    localparam int BLK  = 2 * HALF_DEF;
    localparam int GRAN = BLK * SUBBANDS_DEF;
    localparam int MAXV = (1 << (N_DEF - 1)) - 1;
    localparam int MINV = -(1 << (N_DEF - 1));

    typedef struct {
        logic signed [N_DEF-1:0] s;
        logic                    last;
        int                      idx;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clear;

    imdct_overlap_add_if bus ();

    imdct_overlap_add dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic signed [N_DEF-1:0] mdl_mem [DEPTH_DEF];
    int                      mdl_k;
    exp_t                    exp_q [$];
    logic signed [N_DEF-1:0] in_q [$];
    logic signed [N_DEF-1:0] got_q [$];
    int                      last_pos [$];
    int                      n_out;
    int                      stall_hits;

    task automatic mdl_reset();
        foreach (mdl_mem[i]) mdl_mem[i] = '0;
        mdl_k = 0;
        exp_q.delete();
    endtask

    task automatic mdl_accept(input logic signed [N_DEF-1:0] s);
        int   idx;
        int   sb;
        int   a;
        int   sum;
        exp_t e;
        idx = mdl_k % BLK;
        sb  = (mdl_k / BLK) % SUBBANDS_DEF;
        a   = sb * HALF_DEF + (idx % HALF_DEF);
        if (idx < HALF_DEF) begin
            sum = int'(s) + int'(mdl_mem[a]);
            if (sum > MAXV) sum = MAXV;
            if (sum < MINV) sum = MINV;
            e.s    = N_DEF'(sum);
            e.last = (sb == SUBBANDS_DEF - 1) && (idx == HALF_DEF - 1);
            e.idx  = idx;
            exp_q.push_back(e);
        end else begin
            mdl_mem[a] = s;
        end
        mdl_k++;
    endtask

    task automatic clear_logs();
        got_q.delete();
        last_pos.delete();
        n_out = 0;
    endtask

    // Counts cycles with in_ready low from the current negedge; expects 576.
    task automatic wait_clear(input string name);
        int n;
        bit ov_seen;
        n       = 0;
        ov_seen = 0;
        #1;
        while (bus.in_ready === 1'b0 && n < 2000) begin
            if (bus.out_valid !== 1'b0) ov_seen = 1;
            n++;
            @(negedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        total++;
        if (n !== DEPTH_DEF) begin
            bad++;
            $display("FAIL %s_clear_cycles got=%0d exp=%0d", name, n, DEPTH_DEF);
        end
        total++;
        if (ov_seen) begin
            bad++;
            $display("FAIL %s_outvalid_in_clear got=1 exp=0", name);
        end
    endtask

    // Streams in_q through the DUT with random valid/ready; entered at a negedge.
    task automatic stream(input int vprob, input int rprob, input int stall_idx, input bit drain);
        int                      cyc;
        int                      stall_left;
        bit                      stalled_done;
        bit                      p_stall;
        logic signed [N_DEF-1:0] prev_s;
        logic                    prev_l;
        exp_t                    e;
        cyc          = 0;
        stall_left   = 0;
        stalled_done = 0;
        p_stall      = 0;
        prev_s       = '0;
        prev_l       = 1'b0;
        while ((in_q.size() > 0 || (drain && exp_q.size() > 0)) && cyc < 20000) begin
            if (stall_idx >= 0 && !stalled_done && bus.out_valid === 1'b1 &&
                exp_q.size() > 0 && exp_q[0].idx == stall_idx) begin
                stall_left   = 10;
                stalled_done = 1;
            end
            if (stall_left > 0) bus.out_ready = 1'b0;
            #1;
            if (p_stall) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_sample !== prev_s || bus.out_last !== prev_l) begin
                    bad++;
                    $display("FAIL hold_stable got=%0b/%0d/%0b exp=1/%0d/%0b",
                             bus.out_valid, bus.out_sample, bus.out_last, prev_s, prev_l);
                end
            end
            if (stall_left > 0) begin
                total++;
                stall_hits++;
                if (bus.in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_ready got=%0b exp=0", bus.in_ready);
                end
                stall_left--;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output got=%0d exp=none", bus.out_sample);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_sample !== e.s || bus.out_last !== e.last) begin
                        bad++;
                        $display("FAIL out_%0d got=%0d last=%0b exp=%0d last=%0b",
                                 n_out, bus.out_sample, bus.out_last, e.s, e.last);
                    end
                end
                got_q.push_back(bus.out_sample);
                if (bus.out_last === 1'b1) last_pos.push_back(n_out);
                n_out++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                mdl_accept(in_q.pop_front());
            end
            p_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            prev_s  = bus.out_sample;
            prev_l  = bus.out_last;
            @(posedge clk);
            #1;
            bus.in_valid  = (in_q.size() > 0) && ($urandom_range(99) < vprob);
            bus.in_sample = bus.in_valid ? in_q[0] : N_DEF'($urandom);
            bus.out_ready = ($urandom_range(99) < rprob);
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        total++;
        if (cyc >= 20000) begin
            bad++;
            $display("FAIL stream_timeout got=%0d exp<20000 pending_in=%0d pending_out=%0d",
                     cyc, in_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.out_ready = 1'b0;
        #1;
        total += 4;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
        if (bus.out_sample !== '0) begin bad++; $display("FAIL rst_out_sample got=%0d exp=0", bus.out_sample); end
        if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%0b exp=0", bus.out_last); end
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
        repeat (3) @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_sample = 18'sd1234;
        rst_n         = 1'b1;
        wait_clear("reset");
        mdl_reset();
    endtask

    task automatic test_passthrough();
        logic signed [N_DEF-1:0] src [$];
        clear_logs();
        for (int k = 0; k < GRAN; k++) in_q.push_back(N_DEF'($urandom));
        src = in_q;
        stream(100, 100, -1, 1);
        total++;
        if (got_q.size() != GRAN / 2) begin
            bad++;
            $display("FAIL pass_count got=%0d exp=%0d", got_q.size(), GRAN / 2);
        end else begin
            for (int j = 0; j < GRAN / 2; j++) begin
                total++;
                if (got_q[j] !== src[(j / HALF_DEF) * BLK + (j % HALF_DEF)]) begin
                    bad++;
                    $display("FAIL pass_raw_%0d got=%0d exp=%0d", j, got_q[j],
                             src[(j / HALF_DEF) * BLK + (j % HALF_DEF)]);
                end
            end
        end
    endtask

    task automatic test_two_granules();
        clear_logs();
        for (int k = 0; k < GRAN; k++) in_q.push_back(18'sd100);
        for (int k = 0; k < GRAN; k++) in_q.push_back(18'sd5);
        stream(90, 85, -1, 1);
        total++;
        if (got_q.size() != GRAN) begin
            bad++;
            $display("FAIL two_count got=%0d exp=%0d", got_q.size(), GRAN);
        end else begin
            for (int j = GRAN / 2; j < GRAN; j++) begin
                total++;
                if (got_q[j] !== 18'sd105) begin
                    bad++;
                    $display("FAIL two_sum_%0d got=%0d exp=105", j, got_q[j]);
                end
            end
        end
        total++;
        if (last_pos.size() != 2 || last_pos[0] != GRAN / 2 - 1 || last_pos[1] != GRAN - 1) begin
            bad++;
            $display("FAIL two_last got=%0d marks first=%0d exp=2 marks at %0d,%0d",
                     last_pos.size(), (last_pos.size() > 0) ? last_pos[0] : -1,
                     GRAN / 2 - 1, GRAN - 1);
        end
    endtask

    task automatic test_saturation();
        int idx;
        int sb;
        clear_logs();
        for (int k = 0; k < GRAN; k++) begin
            idx = k % BLK;
            sb  = k / BLK;
            if (idx >= HALF_DEF && sb == 0)      in_q.push_back(N_DEF'(MAXV));
            else if (idx >= HALF_DEF && sb == 1) in_q.push_back(N_DEF'(MINV));
            else                                 in_q.push_back(N_DEF'($urandom));
        end
        for (int k = 0; k < GRAN; k++) begin
            idx = k % BLK;
            sb  = k / BLK;
            if (idx < HALF_DEF && sb == 0)      in_q.push_back(18'sd1);
            else if (idx < HALF_DEF && sb == 1) in_q.push_back(-18'sd1);
            else                                in_q.push_back(N_DEF'($urandom));
        end
        stream(95, 95, -1, 1);
        total++;
        if (got_q.size() != GRAN) begin
            bad++;
            $display("FAIL sat_count got=%0d exp=%0d", got_q.size(), GRAN);
        end else begin
            for (int j = 0; j < HALF_DEF; j++) begin
                total += 2;
                if (got_q[GRAN / 2 + j] !== 18'sd131071) begin
                    bad++;
                    $display("FAIL sat_pos_%0d got=%0d exp=131071", j, got_q[GRAN / 2 + j]);
                end
                if (got_q[GRAN / 2 + HALF_DEF + j] !== -18'sd131072) begin
                    bad++;
                    $display("FAIL sat_neg_%0d got=%0d exp=-131072", j, got_q[GRAN / 2 + HALF_DEF + j]);
                end
            end
        end
    endtask

    task automatic test_random();
        clear_logs();
        for (int k = 0; k < 2 * GRAN; k++) in_q.push_back(N_DEF'($urandom));
        stream(70, 60, -1, 1);
        total++;
        if (last_pos.size() != 2) begin
            bad++;
            $display("FAIL rand_last_count got=%0d exp=2", last_pos.size());
        end
    endtask

    task automatic test_stall();
        clear_logs();
        stall_hits = 0;
        for (int k = 0; k < GRAN; k++) in_q.push_back(N_DEF'($urandom));
        stream(100, 100, 3, 1);
        total++;
        if (stall_hits != 10) begin
            bad++;
            $display("FAIL stall_cycles got=%0d exp=10", stall_hits);
        end
        total++;
        if (got_q.size() != GRAN / 2) begin
            bad++;
            $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), GRAN / 2);
        end
    endtask

    task automatic test_clear();
        logic signed [N_DEF-1:0] src [$];
        clear_logs();
        for (int k = 0; k < 7 * BLK + 20; k++) in_q.push_back(N_DEF'($urandom));
        stream(80, 80, -1, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_drop1 got=%0b exp=0", bus.out_valid);
        end
        wait_clear("clear1");
        mdl_reset();
        // leave one output pending, then clear must drop it
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_sample = 18'sd777;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_sample !== 18'sd777) begin
            bad++;
            $display("FAIL clear_pending got=%0b/%0d exp=1/777", bus.out_valid, bus.out_sample);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_drop2 got=%0b exp=0", bus.out_valid);
        end
        wait_clear("clear2");
        mdl_reset();
        clear_logs();
        for (int k = 0; k < GRAN; k++) in_q.push_back(N_DEF'($urandom));
        src = in_q;
        stream(85, 85, -1, 1);
        total++;
        if (got_q.size() != GRAN / 2) begin
            bad++;
            $display("FAIL clear_count got=%0d exp=%0d", got_q.size(), GRAN / 2);
        end else begin
            for (int j = 0; j < GRAN / 2; j++) begin
                total++;
                if (got_q[j] !== src[(j / HALF_DEF) * BLK + (j % HALF_DEF)]) begin
                    bad++;
                    $display("FAIL clear_raw_%0d got=%0d exp=%0d", j, got_q[j],
                             src[(j / HALF_DEF) * BLK + (j % HALF_DEF)]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [N_DEF-1:0] src [$];
        clear_logs();
        for (int k = 0; k < 12 * BLK + 5; k++) in_q.push_back(N_DEF'($urandom));
        stream(90, 90, -1, 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total += 4;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%0b exp=0", bus.out_valid); end
        if (bus.out_sample !== '0) begin bad++; $display("FAIL mid_rst_out_sample got=%0d exp=0", bus.out_sample); end
        if (bus.out_last !== 1'b0) begin bad++; $display("FAIL mid_rst_out_last got=%0b exp=0", bus.out_last); end
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%0b exp=0", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("mid_reset");
        mdl_reset();
        clear_logs();
        for (int k = 0; k < GRAN; k++) in_q.push_back(N_DEF'($urandom));
        src = in_q;
        stream(90, 75, -1, 1);
        total++;
        if (got_q.size() != GRAN / 2) begin
            bad++;
            $display("FAIL mid_count got=%0d exp=%0d", got_q.size(), GRAN / 2);
        end else begin
            for (int j = 0; j < GRAN / 2; j++) begin
                total++;
                if (got_q[j] !== src[(j / HALF_DEF) * BLK + (j % HALF_DEF)]) begin
                    bad++;
                    $display("FAIL mid_raw_%0d got=%0d exp=%0d", j, got_q[j],
                             src[(j / HALF_DEF) * BLK + (j % HALF_DEF)]);
                end
            end
        end
    endtask

    initial begin
        stall_hits = 0;
        n_out      = 0;
        mdl_k      = 0;
        test_reset();
        test_passthrough();
        test_two_granules();
        test_saturation();
        test_random();
        test_stall();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imdct_overlap_add.md
IMDCT_OVERLAP_ADD -- requirements
Module: imdct_overlap_add

Interface
REQ-001 Parameter N, default 18: signed sample width, two's complement.
REQ-002 Parameter SUBBANDS, default 32: subbands per granule.
REQ-003 Parameter HALF, default 18: half IMDCT block length; full block is 2*HALF samples.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 clear  input  1  one-cycle pulse; restarts overlap-memory clearing (new stream/channel).
REQ-007 in_valid  input  1  in_sample is valid.
REQ-008 in_ready  output  1  block accepts in_sample this cycle.
REQ-009 in_sample  input  N  IMDCT output sample, order: subband 0..SUBBANDS-1, index 0..2*HALF-1 within a subband.
REQ-010 out_valid  output  1  out_sample is valid.
REQ-011 out_ready  input  1  downstream accepts out_sample.
REQ-012 out_sample  output  N  overlap-added, saturated time sample.
REQ-013 out_last  output  1  high with the final output of a granule (subband SUBBANDS-1, index HALF-1).

Function
REQ-014 States: CLEAR, RUN; reset enters CLEAR.
REQ-015 CLEAR writes zero to all SUBBANDS*HALF memory words, one per cycle, at addresses 0 to SUBBANDS*HALF-1; in_ready is 0 throughout.
REQ-016 CLEAR -> RUN the cycle after address SUBBANDS*HALF-1 is written (576 cycles at defaults).
REQ-017 clear=1 in any state forces CLEAR with address 0 next cycle; index/subband counters return to 0; any pending output is dropped (out_valid=0).
REQ-018 Internal counters idx (0..2*HALF-1) and sb (0..SUBBANDS-1) advance only on an input handshake (in_valid && in_ready); idx wraps 2*HALF-1 -> 0 and increments sb; sb wraps SUBBANDS-1 -> 0.
REQ-019 Memory address = sb*HALF + (idx mod HALF).
REQ-020 idx < HALF: out_sample = sat(in_sample + mem[addr]) registered; out_valid rises the cycle after the handshake (latency 1).
REQ-021 idx >= HALF: mem[addr] <= in_sample; no output produced.
REQ-022 In RUN, in_ready = 1 when idx >= HALF; when idx < HALF, in_ready = !out_valid || out_ready (single-entry output register, full throughput).
REQ-023 out_valid/out_sample/out_last hold stable while out_valid && !out_ready.
REQ-024 Saturation: sum formed at N+1 bits, clamped to [-2^(N-1), 2^(N-1)-1].
REQ-025 out_last = 1 exactly for the output from sb=SUBBANDS-1, idx=HALF-1.
REQ-026 in_valid with in_ready=0 has no effect; in_sample need not be held stable by the block.

Reset
REQ-027 rst_n=0 asynchronously sets: state CLEAR, clear address 0, idx 0, sb 0, out_valid 0, out_sample 0, out_last 0, in_ready 0.
REQ-028 Memory contents are not reset directly; CLEAR after reset guarantees zeros before the first RUN input.
REQ-029 Reset asserted mid-granule discards the partial granule; no output emitted after deassertion until new inputs.

Structure
REQ-030 Package imdct_pkg holds N, HALF, SUBBANDS defaults, memory depth constant and the state enumeration.
REQ-031 One sub-module overlap_ram: SUBBANDS*HALF x N, one synchronous write port, one asynchronous read port.

Verification
REQ-032 Reset release, in_valid=1: in_ready=0 for 576 cycles, then 1; first granule outputs equal inputs idx 0..17 unchanged.
REQ-033 Two granules, all samples 100 in granule 1, 5 in granule 2: granule-2 outputs all 105; out_last once per granule, at the 576th output.
REQ-034 Saturation: stored 131071, input 1 -> out 131071; stored -131072, input -1 -> out -131072.
REQ-035 out_ready held 0 for 10 cycles at idx 3: out_sample stable, in_ready=0, no data lost; stream resumes in order.
REQ-036 clear pulse at sb=7, idx=20: out_valid drops next cycle, 576 CLEAR cycles, next granule outputs equal raw inputs.
REQ-037 rst_n pulsed low asynchronously mid-cycle at sb=12: all outputs 0 immediately, CLEAR restarts from address 0.
